// File: rtl/hazard_unit.sv
// hazard_unit: RV32I 5-stage pipeline hold/squash control, EX forwarding select,
// and data-memory wait FSM with sticky timeout error and saturating stall counter.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       rs1_EX,
    input  logic [4:0]       rs2_EX,
    input  logic [4:0]       reg_dest_EX,
    input  logic [4:0]       reg_dest_MEM,
    input  logic [4:0]       reg_dest_WB,
    input  logic             reg_write_EX,
    input  logic             reg_write_MEM,
    input  logic             reg_write_WB,
    input  logic             mem_read_EX,
    input  logic             br_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [1:0]       fwd_rs1_EX,
    output logic [1:0]       fwd_rs2_EX,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t           r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_count;

    logic w_mem_stall;
    logic w_load_use;
    logic w_branch;
    logic w_lu;
    logic w_mem_fwd1, w_wb_fwd1, w_mem_fwd2, w_wb_fwd2;

    assign w_mem_stall = (r_state == RUN && mem_req_MEM && !mem_ready)
                      || (r_state == WAIT && !mem_ready)
                      || (r_state == ERR);
    assign w_load_use  = mem_read_EX && reg_write_EX && reg_dest_EX != 5'd0
                      && (reg_dest_EX == rs1_ID || reg_dest_EX == rs2_ID);
    // One condition per cycle: memory stall, then branch, then load-use.
    assign w_branch    = !w_mem_stall && br_taken_EX;
    assign w_lu        = !w_mem_stall && !br_taken_EX && w_load_use;

    assign bubbleF = rst_n && (w_mem_stall || w_lu);
    assign bubbleD = rst_n && (w_mem_stall || w_lu);
    assign bubbleE = rst_n && w_mem_stall;
    assign bubbleM = rst_n && w_mem_stall;
    assign bubbleW = 1'b0;
    assign flushD  = !rst_n || w_branch;
    assign flushE  = !rst_n || w_branch || w_lu;
    assign flushM  = !rst_n;
    assign flushW  = !rst_n || w_mem_stall;

    assign w_mem_fwd1 = reg_write_MEM && reg_dest_MEM != 5'd0 && reg_dest_MEM == rs1_EX;
    assign w_wb_fwd1  = reg_write_WB && reg_dest_WB != 5'd0 && reg_dest_WB == rs1_EX;
    assign w_mem_fwd2 = reg_write_MEM && reg_dest_MEM != 5'd0 && reg_dest_MEM == rs2_EX;
    assign w_wb_fwd2  = reg_write_WB && reg_dest_WB != 5'd0 && reg_dest_WB == rs2_EX;

    assign fwd_rs1_EX = !rst_n ? 2'b00 : w_mem_fwd1 ? 2'b01 : w_wb_fwd1 ? 2'b10 : 2'b00;
    assign fwd_rs2_EX = !rst_n ? 2'b00 : w_mem_fwd2 ? 2'b01 : w_wb_fwd2 ? 2'b10 : 2'b00;

    assign mem_err     = r_mem_err;
    assign stall_count = r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_err     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            if (bubbleF && r_stall_count != {CNT_W{1'b1}})
                r_stall_count <= r_stall_count + 1'b1;
            case (r_state)
                RUN: if (mem_req_MEM && !mem_ready) begin
                    r_state    <= WAIT;
                    r_wait_cnt <= WC_W'(1);
                end
                WAIT: if (mem_ready) begin
                    r_state <= RUN;
                end else if (r_wait_cnt == WC_W'(MEM_TIMEOUT)) begin
                    r_state   <= ERR;
                    r_mem_err <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                ERR: r_state <= ERR;
                default: r_state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of hazard_unit with MEM_TIMEOUT=4, CNT_W=3.
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX;
    logic [4:0] reg_dest_EX, reg_dest_MEM, reg_dest_WB;
    logic       reg_write_EX, reg_write_MEM, reg_write_WB;
    logic       mem_read_EX, br_taken_EX, mem_req_MEM, mem_ready;
    logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic       flushD, flushE, flushM, flushW;
    logic [1:0] fwd_rs1_EX, fwd_rs2_EX;
    logic       mem_err;
    logic [2:0] stall_count;
    logic [8:0] ctl;

    int checks = 0;
    int failures = 0;

    localparam logic [8:0] C_IDLE   = 9'b00000_0000;
    localparam logic [8:0] C_RESET  = 9'b00000_1111;
    localparam logic [8:0] C_LU     = 9'b11000_0100;
    localparam logic [8:0] C_BRANCH = 9'b00000_1100;
    localparam logic [8:0] C_STALL  = 9'b11110_0001;

    hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
        .reg_dest_EX(reg_dest_EX), .reg_dest_MEM(reg_dest_MEM), .reg_dest_WB(reg_dest_WB),
        .reg_write_EX(reg_write_EX), .reg_write_MEM(reg_write_MEM), .reg_write_WB(reg_write_WB),
        .mem_read_EX(mem_read_EX), .br_taken_EX(br_taken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
        .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .fwd_rs1_EX(fwd_rs1_EX), .fwd_rs2_EX(fwd_rs2_EX),
        .mem_err(mem_err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    assign ctl = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushD, flushE, flushM, flushW};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        {rs1_ID, rs2_ID, rs1_EX, rs2_EX} = '0;
        {reg_dest_EX, reg_dest_MEM, reg_dest_WB} = '0;
        {reg_write_EX, reg_write_MEM, reg_write_WB} = '0;
        {mem_read_EX, br_taken_EX, mem_req_MEM, mem_ready} = '0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        reg_write_MEM = 1'b1; reg_dest_MEM = 5'd7; rs1_EX = 5'd7;
        #2;
        chk("reset_ctl", 32'(ctl), 32'(C_RESET));
        chk("reset_fwd1", 32'(fwd_rs1_EX), 32'd0);
        chk("reset_err", 32'(mem_err), 32'd0);
        chk("reset_cnt", 32'(stall_count), 32'd0);
        clear_inputs();
        tick; tick;
        rst_n = 1'b1;
        #1 chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

        tick;
        mem_read_EX = 1'b1; reg_write_EX = 1'b1; reg_dest_EX = 5'd5; rs2_ID = 5'd5;
        #1 chk("lu_ctl", 32'(ctl), 32'(C_LU));
        chk("lu_cnt0", 32'(stall_count), 32'd0);
        tick;
        clear_inputs();
        #1 chk("lu_cnt1", 32'(stall_count), 32'd1);
        chk("lu_after_ctl", 32'(ctl), 32'(C_IDLE));

        tick;
        mem_read_EX = 1'b1; reg_write_EX = 1'b1; reg_dest_EX = 5'd0; rs1_ID = 5'd0; rs2_ID = 5'd5;
        #1 chk("lu_x0_ctl", 32'(ctl), 32'(C_IDLE));
        tick;
        clear_inputs();
        #1 chk("lu_x0_cnt", 32'(stall_count), 32'd1);

        reg_dest_MEM = 5'd7; reg_dest_WB = 5'd7; reg_write_MEM = 1'b1; reg_write_WB = 1'b1; rs1_EX = 5'd7;
        #1 chk("fwd_mem", 32'(fwd_rs1_EX), 32'd1);
        chk("fwd_rs2_rf", 32'(fwd_rs2_EX), 32'd0);
        reg_write_MEM = 1'b0; rs2_EX = 5'd7;
        #1 chk("fwd_wb", 32'(fwd_rs1_EX), 32'd2);
        chk("fwd_rs2_wb", 32'(fwd_rs2_EX), 32'd2);
        rs1_EX = 5'd0;
        #1 chk("fwd_x0_rs", 32'(fwd_rs1_EX), 32'd0);
        reg_write_MEM = 1'b1; reg_dest_MEM = 5'd0; reg_dest_WB = 5'd0;
        #1 chk("fwd_x0_dest", 32'(fwd_rs1_EX), 32'd0);
        clear_inputs();

        tick;
        br_taken_EX = 1'b1;
        #1 chk("br_ctl", 32'(ctl), 32'(C_BRANCH));
        mem_read_EX = 1'b1; reg_write_EX = 1'b1; reg_dest_EX = 5'd5; rs2_ID = 5'd5;
        #1 chk("br_over_lu", 32'(ctl), 32'(C_BRANCH));
        tick;
        clear_inputs();
        #1 chk("br_cnt", 32'(stall_count), 32'd1);

        mem_req_MEM = 1'b1; mem_ready = 1'b0;
        #1 chk("miss_c1", 32'(ctl), 32'(C_STALL));
        tick;
        #1 chk("miss_c2", 32'(ctl), 32'(C_STALL));
        tick;
        #1 chk("miss_c3", 32'(ctl), 32'(C_STALL));
        tick;
        mem_ready = 1'b1;
        #1 chk("miss_done", 32'(ctl), 32'(C_IDLE));
        chk("miss_cnt", 32'(stall_count), 32'd4);
        tick;
        mem_req_MEM = 1'b0; mem_ready = 1'b0;
        #1 chk("miss_run", 32'(ctl), 32'(C_IDLE));

        tick;
        mem_req_MEM = 1'b1; br_taken_EX = 1'b1;
        #1 chk("missbr_c1", 32'(ctl), 32'(C_STALL));
        tick;
        #1 chk("missbr_c2", 32'(ctl), 32'(C_STALL));
        tick;
        #1 chk("missbr_c3", 32'(ctl), 32'(C_STALL));
        tick;
        mem_ready = 1'b1;
        #1 chk("missbr_done", 32'(ctl), 32'(C_BRANCH));
        chk("missbr_cnt", 32'(stall_count), 32'd7);
        tick;
        clear_inputs();
        #1 chk("missbr_idle", 32'(ctl), 32'(C_IDLE));

        #1 rst_n = 1'b0;
        #1 chk("rst2_cnt", 32'(stall_count), 32'd0);
        chk("rst2_ctl", 32'(ctl), 32'(C_RESET));
        tick;
        rst_n = 1'b1;

        mem_req_MEM = 1'b1; mem_ready = 1'b1;
        #1 chk("zw_ctl", 32'(ctl), 32'(C_IDLE));
        tick;
        #1 chk("zw_ctl2", 32'(ctl), 32'(C_IDLE));
        chk("zw_cnt", 32'(stall_count), 32'd0);

        mem_ready = 1'b0;
        #1 chk("to_req", 32'(ctl), 32'(C_STALL));
        tick; tick; tick; tick;
        #1 chk("to_w4_err", 32'(mem_err), 32'd0);
        chk("to_w4_ctl", 32'(ctl), 32'(C_STALL));
        tick;
        #1 chk("to_err", 32'(mem_err), 32'd1);
        chk("to_cnt5", 32'(stall_count), 32'd5);
        mem_req_MEM = 1'b0; mem_ready = 1'b1;
        #1 chk("err_ignore_ready", 32'(ctl), 32'(C_STALL));
        tick;
        #1 chk("err_sticky", 32'(mem_err), 32'd1);
        chk("err_ctl", 32'(ctl), 32'(C_STALL));
        tick; tick; tick; tick;
        #1 chk("cnt_sat", 32'(stall_count), 32'd7);
        chk("err_sticky2", 32'(mem_err), 32'd1);

        #1 rst_n = 1'b0;
        #1 chk("rst_err_clr", 32'(mem_err), 32'd0);
        chk("rst_err_cnt", 32'(stall_count), 32'd0);
        chk("rst_err_ctl", 32'(ctl), 32'(C_RESET));
        tick;
        rst_n = 1'b1; mem_ready = 1'b0;
        #1 chk("post_rst_run", 32'(ctl), 32'(C_IDLE));
        tick;
        #1 chk("post_rst_cnt", 32'(stall_count), 32'd0);
        chk("post_rst_ctl", 32'(ctl), 32'(C_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
